// File: rtl/poly_phase_accum.sv
// Multi-voice phase accumulator: N_VOICES phase/FCW registers streamed round-robin on one valid/ready channel.
// Optional POLY_ACCUM_WRAP_EN adds out_wrap, flagging samples whose last accepted increment carried out.
module poly_phase_accum #(
   parameter  int unsigned N_VOICES    = 4,
   parameter  int unsigned PHASE_W     = 24,
   localparam int unsigned VOICE_IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [VOICE_IDX_W-1:0] cmd_voice,
   input  logic [PHASE_W-1:0]     cmd_fcw,
   input  logic                   cmd_start,
   input  logic                   cmd_release,
   input  logic                   cmd_reset,
   input  logic                   cmd_fcw_wr,
   output logic [PHASE_W-1:0]     out_phase,
   output logic [VOICE_IDX_W-1:0] out_voice,
   output logic                   out_first,
   output logic                   out_valid,
   input  logic                   out_ready
`ifdef POLY_ACCUM_WRAP_EN
   ,output logic                  out_wrap
`endif
);

   typedef enum logic {
      V_IDLE   = 1'b0,
      V_ACTIVE = 1'b1
   } voice_state_e;

   voice_state_e           state_q [N_VOICES];
   voice_state_e           state_d [N_VOICES];
   logic [PHASE_W-1:0]     phase_q [N_VOICES];
   logic [PHASE_W-1:0]     phase_d [N_VOICES];
   logic [PHASE_W-1:0]     fcw_q   [N_VOICES];
   logic [PHASE_W-1:0]     fcw_d   [N_VOICES];
   logic [VOICE_IDX_W-1:0] ptr_q;
   logic [VOICE_IDX_W-1:0] ptr_d;
`ifdef POLY_ACCUM_WRAP_EN
   logic                   wrap_q  [N_VOICES];
   logic                   wrap_d  [N_VOICES];
`endif

   logic               handshake_c;
   logic               cmd_hit_c;
   logic [PHASE_W:0]   incr_c;

   // Presentation is a pure mux of the registered slot selected by ptr.
   assign out_voice   = ptr_q;
   assign out_phase   = phase_q[ptr_q];
   assign out_valid   = (state_q[ptr_q] == V_ACTIVE);
   assign out_first   = (ptr_q == '0);
`ifdef POLY_ACCUM_WRAP_EN
   assign out_wrap    = wrap_q[ptr_q] && out_valid;
`endif

   assign handshake_c = out_valid && out_ready;
   assign cmd_hit_c   = (32'(cmd_voice) < N_VOICES);
   // One shared adder: only the presented voice can advance in a cycle.
   assign incr_c      = {1'b0, phase_q[ptr_q]} + {1'b0, fcw_q[ptr_q]};

   // Next-state: accumulate on handshake, then let commands override (reset > release > start > fcw_wr).
   always_comb begin
      ptr_d = ptr_q;
      for (int unsigned v = 0; v < N_VOICES; v++) begin
         state_d[v] = state_q[v];
         phase_d[v] = phase_q[v];
         fcw_d[v]   = fcw_q[v];
`ifdef POLY_ACCUM_WRAP_EN
         wrap_d[v]  = wrap_q[v];
`endif
         if (handshake_c && (ptr_q == VOICE_IDX_W'(v))) begin
            phase_d[v] = incr_c[PHASE_W-1:0];
`ifdef POLY_ACCUM_WRAP_EN
            wrap_d[v]  = incr_c[PHASE_W];
`endif
         end
         if (cmd_hit_c && (cmd_voice == VOICE_IDX_W'(v))) begin
            if (cmd_reset) begin
               state_d[v] = V_IDLE;
               phase_d[v] = '0;
`ifdef POLY_ACCUM_WRAP_EN
               wrap_d[v]  = 1'b0;
`endif
            end else if (cmd_release) begin
               // Release discards any same-cycle increment.
               state_d[v] = V_IDLE;
               phase_d[v] = phase_q[v];
`ifdef POLY_ACCUM_WRAP_EN
               wrap_d[v]  = wrap_q[v];
`endif
            end else if (cmd_start) begin
               state_d[v] = V_ACTIVE;
               phase_d[v] = '0;
               fcw_d[v]   = cmd_fcw;
`ifdef POLY_ACCUM_WRAP_EN
               wrap_d[v]  = 1'b0;
`endif
            end else if (cmd_fcw_wr) begin
               fcw_d[v]   = cmd_fcw;
            end
         end
      end
      if (!out_valid || out_ready) begin
         ptr_d = (ptr_q == VOICE_IDX_W'(N_VOICES - 1)) ? '0 : ptr_q + VOICE_IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         for (int unsigned v = 0; v < N_VOICES; v++) begin
            state_q[v] <= V_IDLE;
            phase_q[v] <= '0;
            fcw_q[v]   <= '0;
`ifdef POLY_ACCUM_WRAP_EN
            wrap_q[v]  <= 1'b0;
`endif
         end
      end else begin
         ptr_q <= ptr_d;
         for (int unsigned v = 0; v < N_VOICES; v++) begin
            state_q[v] <= state_d[v];
            phase_q[v] <= phase_d[v];
            fcw_q[v]   <= fcw_d[v];
`ifdef POLY_ACCUM_WRAP_EN
            wrap_q[v]  <= wrap_d[v];
`endif
         end
      end
   end

endmodule
